// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the decode stage: instruction codes, register IDs,
// status codes and the control half of the D->E pipeline register.
package y86_pkg;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   // Width-independent part of the E register; data words live beside it.
   typedef struct packed {
      logic [2:0] stat;
      logic [3:0] icode;
      logic [3:0] ifun;
      logic [3:0] dst_e;
      logic [3:0] dst_m;
      logic [3:0] src_a;
      logic [3:0] src_b;
   } e_ctl_t;

   localparam e_ctl_t E_CTL_BUBBLE = '{
      stat:  STAT_AOK,
      icode: ICODE_NOP,
      ifun:  4'h0,
      dst_e: RNONE,
      dst_m: RNONE,
      src_a: RNONE,
      src_b: RNONE
   };

endpackage

// File: rtl/reg_file.sv
// Y86-64 register file: 2 read / 2 write ports, M write beats E write on the same ID.
// DECODE_WB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module reg_file
   import y86_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREG  = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       src_a,
   input  logic [3:0]       src_b,
   output logic [WIDTH-1:0] val_a,
   output logic [WIDTH-1:0] val_b,
   input  logic [3:0]       dst_e,
   input  logic [WIDTH-1:0] val_e,
   input  logic [3:0]       dst_m,
   input  logic [WIDTH-1:0] val_m
);

   logic [WIDTH-1:0] regs [NREG];

   // NOTE: the array is cleared by a reset loop on purpose; software expects every
   // register to read 0 after reset, so this cannot be left to RAM inference.
   // NOTE: non-blocking writes, so the later dst_m assignment overrides dst_e
   // within the same edge, which is exactly the popq %rsp rule.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (dst_e != RNONE) regs[dst_e] <= val_e;
         if (dst_m != RNONE) regs[dst_m] <= val_m;
      end
   end

   // NOTE: both outputs get a value on the first lines so no path can infer a latch.
   always_comb begin
      val_a = (src_a == RNONE) ? '0 : regs[src_a];
      val_b = (src_b == RNONE) ? '0 : regs[src_b];
`ifdef DECODE_WB_BYPASS_EN
      if (src_a != RNONE) begin
         if (src_a == dst_m)      val_a = val_m;
         else if (src_a == dst_e) val_a = val_e;
      end
      if (src_b != RNONE) begin
         if (src_b == dst_m)      val_b = val_m;
         else if (src_b == dst_e) val_b = val_e;
      end
`endif
   end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode/writeback stage: register ID selection, status, register file and
// the D->E pipeline register. Optional read bypass via DECODE_WB_BYPASS_EN.
module decode_stage
   import y86_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREG  = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic [WIDTH-1:0] valc,
   input  logic [WIDTH-1:0] valp,
   input  logic             iv,
   input  logic             ime,
   input  logic             e_stall,
   input  logic             e_bubble,
   input  logic [3:0]       w_dstE,
   input  logic [WIDTH-1:0] w_valE,
   input  logic [3:0]       w_dstM,
   input  logic [WIDTH-1:0] w_valM,
   output logic [2:0]       E_stat,
   output logic [3:0]       E_icode,
   output logic [3:0]       E_ifun,
   output logic [WIDTH-1:0] E_valC,
   output logic [WIDTH-1:0] E_valA,
   output logic [WIDTH-1:0] E_valB,
   output logic [3:0]       E_dstE,
   output logic [3:0]       E_dstM,
   output logic [3:0]       E_srcA,
   output logic [3:0]       E_srcB
);

   e_ctl_t           d_ctl;
   e_ctl_t           e_ctl;
   logic [WIDTH-1:0] rf_val_a;
   logic [WIDTH-1:0] rf_val_b;
   logic [WIDTH-1:0] d_val_a;

   always_comb begin
      d_ctl       = E_CTL_BUBBLE;
      d_ctl.icode = icode;
      d_ctl.ifun  = ifun;
      case (icode)
         ICODE_RRMOVQ: begin d_ctl.src_a = rA; d_ctl.dst_e = rB; end
         ICODE_IRMOVQ: d_ctl.dst_e = rB;
         ICODE_RMMOVQ: begin d_ctl.src_a = rA; d_ctl.src_b = rB; end
         ICODE_MRMOVQ: begin d_ctl.src_b = rB; d_ctl.dst_m = rA; end
         ICODE_OPQ:    begin d_ctl.src_a = rA; d_ctl.src_b = rB; d_ctl.dst_e = rB; end
         ICODE_CALL:   begin d_ctl.src_b = RRSP; d_ctl.dst_e = RRSP; end
         ICODE_RET:    begin d_ctl.src_a = RRSP; d_ctl.src_b = RRSP; d_ctl.dst_e = RRSP; end
         ICODE_PUSHQ:  begin d_ctl.src_a = rA; d_ctl.src_b = RRSP; d_ctl.dst_e = RRSP; end
         ICODE_POPQ: begin
            d_ctl.src_a = RRSP;
            d_ctl.src_b = RRSP;
            d_ctl.dst_e = RRSP;
            d_ctl.dst_m = rA;
         end
         default: ;
      endcase
      // Fetch errors outrank the instruction itself; unknown icodes only fault via iv.
      if (ime)                     d_ctl.stat = STAT_ADR;
      else if (!iv)                d_ctl.stat = STAT_INS;
      else if (icode == ICODE_HALT) d_ctl.stat = STAT_HLT;
      else                         d_ctl.stat = STAT_AOK;
   end

   reg_file #(.WIDTH(WIDTH), .NREG(NREG)) u_reg_file (
      .clk   (clk),
      .reset (reset),
      .src_a (d_ctl.src_a),
      .src_b (d_ctl.src_b),
      .val_a (rf_val_a),
      .val_b (rf_val_b),
      .dst_e (w_dstE),
      .val_e (w_valE),
      .dst_m (w_dstM),
      .val_m (w_valM)
   );

   // jXX and call carry the fall-through / return address in valA.
   assign d_val_a = (icode == ICODE_JXX || icode == ICODE_CALL) ? valp : rf_val_a;

   always_ff @(posedge clk) begin
      if (reset || e_bubble) begin
         e_ctl  <= E_CTL_BUBBLE;
         E_valC <= '0;
         E_valA <= '0;
         E_valB <= '0;
      end else if (!e_stall) begin
         e_ctl  <= d_ctl;
         E_valC <= valc;
         E_valA <= d_val_a;
         E_valB <= rf_val_b;
      end
   end

   assign E_stat  = e_ctl.stat;
   assign E_icode = e_ctl.icode;
   assign E_ifun  = e_ctl.ifun;
   assign E_dstE  = e_ctl.dst_e;
   assign E_dstM  = e_ctl.dst_m;
   assign E_srcA  = e_ctl.src_a;
   assign E_srcB  = e_ctl.src_b;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// against a behavioural model; honours DECODE_WB_BYPASS_EN when the build defines it.
module tb_decode_stage;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    icode, ifun, rA, rB;
   logic [W-1:0]  valc, valp;
   logic          iv, ime, e_stall, e_bubble;
   logic [3:0]    w_dstE, w_dstM;
   logic [W-1:0]  w_valE, w_valM;
   logic [2:0]    E_stat;
   logic [3:0]    E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [W-1:0]  E_valC, E_valA, E_valB;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]   stat;
      logic [3:0]   icode, ifun, dste, dstm, srca, srcb;
      logic [W-1:0] valc, vala, valb;
   } e_t;

   e_t           exp_e;
   logic [W-1:0] m_regs [15];

   decode_stage #(.WIDTH(W), .NREG(15)) dut (
      .clk(clk), .reset(reset), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valc(valc), .valp(valp), .iv(iv), .ime(ime), .e_stall(e_stall), .e_bubble(e_bubble),
      .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
      .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .E_srcA(E_srcA), .E_srcB(E_srcB)
   );

   always #5 clk = ~clk;

   function automatic e_t bubble_val();
      e_t b;
      b.stat = 3'd1; b.icode = 4'h1; b.ifun = 4'h0;
      b.dste = 4'hF; b.dstm = 4'hF; b.srca = 4'hF; b.srcb = 4'hF;
      b.valc = '0; b.vala = '0; b.valb = '0;
      return b;
   endfunction

   // Register read as seen by decode, including optional forwarding.
   function automatic logic [W-1:0] model_read(input logic [3:0] r);
      if (r == 4'hF) return '0;
`ifdef DECODE_WB_BYPASS_EN
      if (r == w_dstM) return w_valM;
      if (r == w_dstE) return w_valE;
`endif
      return m_regs[r];
   endfunction

   // Advance one clock: predict from pre-edge inputs, then commit after the edge.
   task automatic tick();
      e_t           nx;
      logic [W-1:0] nregs [15];
      nx    = exp_e;
      nregs = m_regs;
      if (reset) begin
         nx = bubble_val();
         for (int i = 0; i < 15; i++) nregs[i] = '0;
      end else begin
         if (e_bubble) nx = bubble_val();
         else if (!e_stall) begin
            nx.icode = icode;
            nx.ifun  = ifun;
            nx.valc  = valc;
            nx.srca  = (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? rA :
                       (icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
            nx.srcb  = (icode inside {4'h4, 4'h5, 4'h6}) ? rB :
                       (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
            nx.dste  = (icode inside {4'h2, 4'h3, 4'h6}) ? rB :
                       (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
            nx.dstm  = (icode inside {4'h5, 4'hB}) ? rA : 4'hF;
            nx.vala  = (icode inside {4'h7, 4'h8}) ? valp : model_read(nx.srca);
            nx.valb  = model_read(nx.srcb);
            nx.stat  = ime ? 3'd3 : !iv ? 3'd4 : (icode == 4'h0) ? 3'd2 : 3'd1;
         end
         if (w_dstE != 4'hF) nregs[w_dstE] = w_valE;
         if (w_dstM != 4'hF) nregs[w_dstM] = w_valM;
      end
      @(posedge clk);
      #1;
      exp_e  = nx;
      m_regs = nregs;
   endtask

   task automatic idle();
      reset = 1'b0; icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
      valc = '0; valp = '0; iv = 1'b1; ime = 1'b0; e_stall = 1'b0; e_bubble = 1'b0;
      w_dstE = 4'hF; w_valE = '0; w_dstM = 4'hF; w_valM = '0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1; icode = 4'h6; rA = 4'h3; rB = 4'h2; valc = 64'hDEAD;
      w_dstE = 4'h3; w_valE = 64'h1234;
      tick();
      tick();
      total++; if (E_icode !== 4'h1) begin bad++; $display("FAIL reset_icode got=%0h want=1", E_icode); end
      total++; if (E_stat  !== 3'd1) begin bad++; $display("FAIL reset_stat got=%0d want=1", E_stat); end
      total++; if (E_dstE  !== 4'hF) begin bad++; $display("FAIL reset_dstE got=%0h want=f", E_dstE); end
      total++; if (E_srcA  !== 4'hF) begin bad++; $display("FAIL reset_srcA got=%0h want=f", E_srcA); end
      total++; if (E_valC  !== '0)   begin bad++; $display("FAIL reset_valC got=%0h want=0", E_valC); end
      idle();
      for (int r = 0; r < 15; r++) begin
         icode = 4'h6; rA = 4'(r); rB = 4'(r);
         tick();
         total++;
         if (E_valA !== '0 || E_valB !== '0) begin
            bad++; $display("FAIL reset_reg%0d got=%0h/%0h want=0/0", r, E_valA, E_valB);
         end
      end
   endtask

   task automatic test_irmovq();
      idle(); icode = 4'h3; rB = 4'h2; valc = 64'h10;
      tick();
      total++; if (E_dstE !== 4'h2)  begin bad++; $display("FAIL irmovq_dstE got=%0h want=2", E_dstE); end
      total++; if (E_srcA !== 4'hF)  begin bad++; $display("FAIL irmovq_srcA got=%0h want=f", E_srcA); end
      total++; if (E_valC !== 64'h10) begin bad++; $display("FAIL irmovq_valC got=%0h want=10", E_valC); end
      idle(); w_dstE = 4'h2; w_valE = 64'h10;
      tick();
      idle(); icode = 4'h6; rA = 4'h2; rB = 4'h2;
      tick();
      total++; if (E_valA !== 64'h10) begin bad++; $display("FAIL opq_valA got=%0h want=10", E_valA); end
      total++; if (E_valB !== 64'h10) begin bad++; $display("FAIL opq_valB got=%0h want=10", E_valB); end
   endtask

   task automatic test_popq_rsp();
      idle(); w_dstE = 4'h4; w_valE = 64'h108; w_dstM = 4'h4; w_valM = 64'h55;
      tick();
      idle(); icode = 4'h2; rA = 4'h4; rB = 4'h1;
      tick();
      total++; if (E_valA !== 64'h55) begin bad++; $display("FAIL popq_rsp got=%0h want=55", E_valA); end
   endtask

   task automatic test_call();
      idle(); icode = 4'h8; valp = 64'h2A; valc = 64'h300;
      tick();
      total++; if (E_valA !== 64'h2A) begin bad++; $display("FAIL call_valA got=%0h want=2a", E_valA); end
      total++; if (E_srcB !== 4'h4)   begin bad++; $display("FAIL call_srcB got=%0h want=4", E_srcB); end
      total++; if (E_dstE !== 4'h4)   begin bad++; $display("FAIL call_dstE got=%0h want=4", E_dstE); end
      total++; if (E_dstM !== 4'hF)   begin bad++; $display("FAIL call_dstM got=%0h want=f", E_dstM); end
      total++; if (E_valB !== 64'h108 && E_valB !== 64'h55) begin
         bad++; $display("FAIL call_valB got=%0h want=55", E_valB);
      end
   endtask

   task automatic test_status();
      idle(); ime = 1'b1; iv = 1'b0;
      tick();
      total++; if (E_stat !== 3'd3) begin bad++; $display("FAIL stat_adr got=%0d want=3", E_stat); end
      idle(); iv = 1'b0;
      tick();
      total++; if (E_stat !== 3'd4) begin bad++; $display("FAIL stat_ins got=%0d want=4", E_stat); end
      idle(); icode = 4'h0;
      tick();
      total++; if (E_stat !== 3'd2) begin bad++; $display("FAIL stat_hlt got=%0d want=2", E_stat); end
      idle(); icode = 4'hD; rA = 4'h1; rB = 4'h2;
      tick();
      total++;
      if (E_stat !== 3'd1 || E_srcA !== 4'hF || E_dstE !== 4'hF) begin
         bad++; $display("FAIL stat_unknown got=%0d/%0h/%0h want=1/f/f", E_stat, E_srcA, E_dstE);
      end
   endtask

   task automatic test_stall_bubble();
      idle(); icode = 4'h3; rB = 4'h5; valc = 64'hAB;
      tick();
      idle(); e_stall = 1'b1; icode = 4'h6; rA = 4'h1; rB = 4'h2; valc = 64'hCD;
      w_dstE = 4'h7; w_valE = 64'h99;
      tick();
      total++; if (E_icode !== 4'h3)  begin bad++; $display("FAIL stall_icode got=%0h want=3", E_icode); end
      total++; if (E_valC !== 64'hAB) begin bad++; $display("FAIL stall_valC got=%0h want=ab", E_valC); end
      total++; if (E_dstE !== 4'h5)   begin bad++; $display("FAIL stall_dstE got=%0h want=5", E_dstE); end
      idle(); e_stall = 1'b1; e_bubble = 1'b1; icode = 4'h6; rA = 4'h7; rB = 4'h7;
      tick();
      total++; if (E_icode !== 4'h1) begin bad++; $display("FAIL bubble_icode got=%0h want=1", E_icode); end
      total++; if (E_dstE !== 4'hF)  begin bad++; $display("FAIL bubble_dstE got=%0h want=f", E_dstE); end
      idle(); icode = 4'h2; rA = 4'h7; rB = 4'h0;
      tick();
      total++; if (E_valA !== 64'h99) begin bad++; $display("FAIL stall_wb got=%0h want=99", E_valA); end
   endtask

   task automatic test_bypass();
      logic [W-1:0] want;
      idle(); w_dstE = 4'h3; w_valE = 64'h11;
      tick();
      idle(); icode = 4'h2; rA = 4'h3; rB = 4'h0; w_dstE = 4'h3; w_valE = 64'h77;
      tick();
`ifdef DECODE_WB_BYPASS_EN
      want = 64'h77;
`else
      want = 64'h11;
`endif
      total++; if (E_valA !== want) begin bad++; $display("FAIL bypass got=%0h want=%0h", E_valA, want); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 49) == 0);
         icode    = 4'($urandom_range(0, 15));
         ifun     = 4'($urandom_range(0, 15));
         rA       = 4'($urandom_range(0, 15));
         rB       = 4'($urandom_range(0, 15));
         valc     = {$urandom, $urandom};
         valp     = {$urandom, $urandom};
         iv       = ($urandom_range(0, 7) != 0);
         ime      = ($urandom_range(0, 15) == 0);
         e_stall  = ($urandom_range(0, 4) == 0);
         e_bubble = ($urandom_range(0, 7) == 0);
         w_dstE   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         w_dstM   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         w_valE   = {$urandom, $urandom};
         w_valM   = {$urandom, $urandom};
         tick();
         total++; if (E_stat  !== exp_e.stat)  begin bad++; $display("FAIL rand%0d stat got=%0h want=%0h", i, E_stat, exp_e.stat); end
         total++; if (E_icode !== exp_e.icode) begin bad++; $display("FAIL rand%0d icode got=%0h want=%0h", i, E_icode, exp_e.icode); end
         total++; if (E_ifun  !== exp_e.ifun)  begin bad++; $display("FAIL rand%0d ifun got=%0h want=%0h", i, E_ifun, exp_e.ifun); end
         total++; if (E_valC  !== exp_e.valc)  begin bad++; $display("FAIL rand%0d valC got=%0h want=%0h", i, E_valC, exp_e.valc); end
         total++; if (E_valA  !== exp_e.vala)  begin bad++; $display("FAIL rand%0d valA got=%0h want=%0h", i, E_valA, exp_e.vala); end
         total++; if (E_valB  !== exp_e.valb)  begin bad++; $display("FAIL rand%0d valB got=%0h want=%0h", i, E_valB, exp_e.valb); end
         total++; if (E_dstE  !== exp_e.dste)  begin bad++; $display("FAIL rand%0d dstE got=%0h want=%0h", i, E_dstE, exp_e.dste); end
         total++; if (E_dstM  !== exp_e.dstm)  begin bad++; $display("FAIL rand%0d dstM got=%0h want=%0h", i, E_dstM, exp_e.dstm); end
         total++; if (E_srcA  !== exp_e.srca)  begin bad++; $display("FAIL rand%0d srcA got=%0h want=%0h", i, E_srcA, exp_e.srca); end
         total++; if (E_srcB  !== exp_e.srcb)  begin bad++; $display("FAIL rand%0d srcB got=%0h want=%0h", i, E_srcB, exp_e.srcb); end
      end
   endtask

   initial begin
      exp_e = bubble_val();
      for (int i = 0; i < 15; i++) m_regs[i] = '0;
      idle();
      reset = 1'b1;
      #1;
      test_reset();
      test_irmovq();
      test_popq_rsp();
      test_call();
      test_status();
      test_stall_bubble();
      test_bypass();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
